disp_hex_mux_gen: RTL and testbench



---
 rtl/disp_pkg.sv | 46 ++++
 rtl/hex_to_sseg.sv | 17 +
 rtl/disp_hex_mux_gen.sv | 131 +++++++++++++
 tb/tb_disp_hex_mux_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display drivers: the active-low hex
// font and the all-off segment pattern.
package disp_pkg;

    localparam logic [7:0] SSEG_OFF = 8'hFF;

    localparam logic [7:0] SSEG_0 = 8'hC0;
    localparam logic [7:0] SSEG_1 = 8'hF9;
    localparam logic [7:0] SSEG_2 = 8'hA4;
    localparam logic [7:0] SSEG_3 = 8'hB0;
    localparam logic [7:0] SSEG_4 = 8'h99;
    localparam logic [7:0] SSEG_5 = 8'h92;
    localparam logic [7:0] SSEG_6 = 8'h82;
    localparam logic [7:0] SSEG_7 = 8'hF8;
    localparam logic [7:0] SSEG_8 = 8'h80;
    localparam logic [7:0] SSEG_9 = 8'h90;
    localparam logic [7:0] SSEG_A = 8'h88;
    localparam logic [7:0] SSEG_B = 8'h83;
    localparam logic [7:0] SSEG_C = 8'hC6;
    localparam logic [7:0] SSEG_D = 8'hA1;
    localparam logic [7:0] SSEG_E = 8'h86;
    localparam logic [7:0] SSEG_F = 8'h8E;

    // Returns the full 8-bit code with the dp bit off; callers overwrite bit 7.
    function automatic logic [7:0] hex2sseg(input logic [3:0] hex);
        case (hex)
            4'h0:    return SSEG_0;
            4'h1:    return SSEG_1;
            4'h2:    return SSEG_2;
            4'h3:    return SSEG_3;
            4'h4:    return SSEG_4;
            4'h5:    return SSEG_5;
            4'h6:    return SSEG_6;
            4'h7:    return SSEG_7;
            4'h8:    return SSEG_8;
            4'h9:    return SSEG_9;
            4'hA:    return SSEG_A;
            4'hB:    return SSEG_B;
            4'hC:    return SSEG_C;
            4'hD:    return SSEG_D;
            4'hE:    return SSEG_E;
            default: return SSEG_F;
        endcase
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex-to-segment decoder with active-low decimal point.
module hex_to_sseg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] sseg
);

    logic [7:0] code;

    always_comb begin
        code = hex2sseg(hex);
        sseg = {~dp, code[6:0]};
    end

endmodule

// File: rtl/disp_hex_mux_gen.sv
// Time-multiplexed N-digit hex display driver with frame snapshots,
// leading-zero blanking, per-digit blink, PWM brightness and a frame pulse.
module disp_hex_mux_gen
    import disp_pkg::*;
#(
    parameter int N_DIG   = 8,
    parameter int DIG_W   = 16,
    parameter int BLINK_W = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4*N_DIG-1:0] hex_in,
    input  logic [N_DIG-1:0]   dp_in,
    input  logic [N_DIG-1:0]   blink_en,
    input  logic               blank_lz,
    input  logic [3:0]         bright,
    output logic [N_DIG-1:0]   an,
    output logic [7:0]         sseg,
    output logic               frame_tick
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

    logic [DIG_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [4*N_DIG-1:0] hex_q, hex_d;
    logic [N_DIG-1:0]   dp_q, dp_d;
    logic [N_DIG-1:0]   blk_q, blk_d;
    logic               lz_q, lz_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [7:0]         sseg_q, sseg_d;
    logic               tick_q, tick_d;

    logic               frame_end;
    logic [N_DIG-1:0]   lz_mask;
    logic               lz_run;
    logic [3:0]         cur_hex;
    logic               cur_dp;
    logic [7:0]         dec_sseg;
    logic [3:0]         sub;
    logic               lit;

    assign frame_end = (&cnt_q) && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        blink_d = blink_q + 1'b1;
        idx_d   = idx_q;
        if (&cnt_q)
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        hex_d = hex_q;
        dp_d  = dp_q;
        blk_d = blk_q;
        lz_d  = lz_q;
        if (frame_end) begin
            hex_d = hex_in;
            dp_d  = dp_in;
            blk_d = blink_en;
            lz_d  = blank_lz;
        end
        tick_d = frame_end;
    end

    // Priority chain from the top digit: blanking runs until a nonzero or dp digit.
    always_comb begin
        lz_mask = '0;
        lz_run  = lz_q;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            if (lz_run && (hex_q[4*i +: 4] == 4'd0) && !dp_q[i])
                lz_mask[i] = 1'b1;
            else
                lz_run = 1'b0;
        end
    end

    always_comb begin
        cur_hex = hex_q[4*int'(idx_q) +: 4];
        cur_dp  = dp_q[idx_q];
    end

    hex_to_sseg u_dec (
        .hex  (cur_hex),
        .dp   (cur_dp),
        .sseg (dec_sseg)
    );

    always_comb begin
        sub = cnt_q[DIG_W-1 -: 4];
        lit = (sub <= bright) && !lz_mask[idx_q]
              && !(blink_q[BLINK_W-1] && blk_q[idx_q]);
        an_d   = '1;
        sseg_d = SSEG_OFF;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            sseg_d      = dec_sseg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            blink_q <= '0;
            hex_q   <= '0;
            dp_q    <= '0;
            blk_q   <= '0;
            lz_q    <= 1'b0;
            an_q    <= '1;
            sseg_q  <= SSEG_OFF;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            blink_q <= blink_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            blk_q   <= blk_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            tick_q  <= tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_hex_mux_gen.sv
// Randomised bench for disp_hex_mux_gen against a time-indexed reference model.
module tb_disp_hex_mux_gen;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int BW    = 8;
    localparam int SLOT  = 1 << DW;
    localparam int FRAME = SLOT * ND;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*ND-1:0] hex_in;
    logic [ND-1:0]   dp_in;
    logic [ND-1:0]   blink_en;
    logic            blank_lz;
    logic [3:0]      bright;
    logic [ND-1:0]   an;
    logic [7:0]      sseg;
    logic            frame_tick;

    disp_hex_mux_gen #(.N_DIG(ND), .DIG_W(DW), .BLINK_W(BW)) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference state: clocks since reset release plus the frame snapshot.
    int            m_t;
    logic [4*ND-1:0] m_hex;
    logic [ND-1:0] m_dp;
    logic [ND-1:0] m_blk;
    logic          m_lz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_t   = 0;
        m_hex = '0;
        m_dp  = '0;
        m_blk = '0;
        m_lz  = 1'b0;
    endtask

    // One clock: predict the registered outputs from elapsed time, then check.
    task automatic step();
        int s, cnt, idx, sub;
        bit blink_ph, blank, run, eft;
        logic [3:0] h;
        logic [ND-1:0] e_an;
        logic [7:0] e_sseg;
        @(posedge clk);
        s   = m_t;
        m_t = m_t + 1;
        cnt = s % SLOT;
        idx = (s / SLOT) % ND;
        sub = cnt >> (DW - 4);
        blink_ph = ((s >> (BW - 1)) & 1) == 1;
        blank = 1'b0;
        run = m_lz;
        for (int d = ND - 1; d >= 1; d--) begin
            if (run && m_hex[4*d +: 4] == 4'd0 && !m_dp[d]) begin
                if (d == idx) blank = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
        if (sub > int'(bright)) blank = 1'b1;
        if (blink_ph && m_blk[idx]) blank = 1'b1;
        e_an = '1;
        e_sseg = 8'hFF;
        if (!blank) begin
            h = m_hex[4*idx +: 4];
            e_an[idx] = 1'b0;
            e_sseg = {~m_dp[idx], font[h][6:0]};
        end
        eft = (s % FRAME) == FRAME - 1;
        if (eft) begin
            m_hex = hex_in;
            m_dp  = dp_in;
            m_blk = blink_en;
            m_lz  = blank_lz;
        end
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("sseg", 32'(sseg), 32'(e_sseg));
        chk("frame_tick", 32'(frame_tick), 32'(eft));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Assert reset off any clock edge and verify the immediate output state.
    task automatic do_reset(input int hold);
        #2 reset = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'hFF);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_hold_an", 32'(an), 32'hF);
        chk("rst_hold_sseg", 32'(sseg), 32'hFF);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        reset    = 1'b1;
        hex_in   = '0;
        dp_in    = '0;
        blink_en = '0;
        blank_lz = 1'b0;
        bright   = 4'd15;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset(5);
        run(FRAME);

        hex_in = 16'h12AF;
        run(3 * FRAME);

        hex_in = 16'h0030;
        blank_lz = 1'b1;
        run(2 * FRAME);
        dp_in = 4'b0100;
        run(2 * FRAME);

        bright = 4'd3;
        run(2 * FRAME);
        bright = 4'd15;

        blink_en = 4'b0001;
        blank_lz = 1'b0;
        dp_in = '0;
        hex_in = 16'h5A3C;
        run(600);

        run(FRAME / 2 + 7);
        hex_in = 16'hBEEF;
        run(FRAME);

        run(SLOT / 2 + 3);
        do_reset(3);
        run(FRAME);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 5))
                    0: hex_in = 16'($urandom);
                    1: hex_in = 16'($urandom_range(0, 255));
                    2: dp_in = 4'($urandom);
                    3: blink_en = 4'($urandom);
                    4: blank_lz = 1'($urandom);
                    default: bright = 4'($urandom);
                endcase
            end
            if (c == 1777) do_reset(2);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
